// File: rtl/mux_2x1_mpc_pkg.sv
// mux_2x1_mpc_pkg: shared select encodings, default sizes and counter type for mux_2x1_mpc
package mux_2x1_mpc_pkg;
  localparam logic SEL_I0 = 1'b0;
  localparam logic SEL_I1 = 1'b1;
  localparam int DEF_WIDTH = 1;
  localparam int DEF_CNT_W = 8;
  typedef logic [DEF_CNT_W-1:0] cnt_t;
endpackage

// File: rtl/mux_2x1_mpc_sat_cnt.sv
// mux_2x1_mpc_sat_cnt: saturating up-counter; clk, rst (async high), inc_i (count enable), cnt_o (count, sticks at all-ones)
module mux_2x1_mpc_sat_cnt
  import mux_2x1_mpc_pkg::*;
#(
  parameter int W = $bits(cnt_t)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d = (inc_i && cnt_q != '1) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/mux_2x1_mpc.sv
// mux_2x1_mpc: 2:1 datapath selector with registered copy and saturating selection counters
// Ports: clk, rst (async high); i0/i1 data, select (0->i0, 1->i1), en capture enable;
//        y combinational result, y_q/y_q_valid registered result, sel0_cnt/sel1_cnt selection stats;
//        err_sticky self-check flag only when MUX_2X1_MPC_CHECK_EN is defined.
module mux_2x1_mpc
  import mux_2x1_mpc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             select,
  input  logic             en,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             y_q_valid,
  output logic [CNT_W-1:0] sel0_cnt,
`ifdef MUX_2X1_MPC_CHECK_EN
  output logic [CNT_W-1:0] sel1_cnt,
  output logic             err_sticky
`else
  output logic [CNT_W-1:0] sel1_cnt
`endif
);
  logic [WIDTH-1:0] y_d;
  logic             valid_d;
  assign y = select ? i1 : i0;
  assign y_d = en ? y : y_q;
  assign valid_d = en;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      y_q       <= '0;
      y_q_valid <= 1'b0;
    end else begin
      y_q       <= y_d;
      y_q_valid <= valid_d;
    end
  mux_2x1_mpc_sat_cnt #(.W(CNT_W)) u_sel0_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc_i(en && select == SEL_I0),
    .cnt_o(sel0_cnt)
  );
  mux_2x1_mpc_sat_cnt #(.W(CNT_W)) u_sel1_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc_i(en && select == SEL_I1),
    .cnt_o(sel1_cnt)
  );
`ifdef MUX_2X1_MPC_CHECK_EN
  // Reference built from and/or masking so it does not share the ternary that drives y_q.
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             err_d;
  assign exp_d = (i0 & ~{WIDTH{select}}) | (i1 & {WIDTH{select}});
  assign err_d = err_sticky | (y_q_valid && y_q != exp_q);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      exp_q      <= '0;
      err_sticky <= 1'b0;
    end else begin
      exp_q      <= en ? exp_d : exp_q;
      err_sticky <= err_d;
    end
`endif
endmodule

// File: tb/tb_mux_2x1_mpc.sv
// tb_mux_2x1_mpc: directed self-checking bench for mux_2x1_mpc
module tb_mux_2x1_mpc;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i0 = 1'b0, i1 = 1'b0, select = 1'b0, en = 1'b0;
  logic       y, y_q, y_q_valid, y2, y2_q, y2_q_valid;
  logic [7:0] sel0_cnt, sel1_cnt;
  logic [1:0] s0_small, s1_small;
  int         checks = 0, errors = 0;
`ifdef MUX_2X1_MPC_CHECK_EN
  logic       err_sticky, err2_sticky;
`endif
  always #5 clk = ~clk;
  mux_2x1_mpc #(.WIDTH(1), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .i0(i0), .i1(i1), .select(select), .en(en),
    .y(y), .y_q(y_q), .y_q_valid(y_q_valid), .sel0_cnt(sel0_cnt),
`ifdef MUX_2X1_MPC_CHECK_EN
    .sel1_cnt(sel1_cnt), .err_sticky(err_sticky)
`else
    .sel1_cnt(sel1_cnt)
`endif
  );
  mux_2x1_mpc #(.WIDTH(1), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .i0(i0), .i1(i1), .select(select), .en(en),
    .y(y2), .y_q(y2_q), .y_q_valid(y2_q_valid), .sel0_cnt(s0_small),
`ifdef MUX_2X1_MPC_CHECK_EN
    .sel1_cnt(s1_small), .err_sticky(err2_sticky)
`else
    .sel1_cnt(s1_small)
`endif
  );
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_reset();
    #1;
    checks += 4;
    if (y_q !== 1'b0) begin errors++; $display("FAIL reset_y_q got %b exp 0", y_q); end
    if (y_q_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", y_q_valid); end
    if (sel0_cnt !== 8'd0) begin errors++; $display("FAIL reset_sel0 got %0d exp 0", sel0_cnt); end
    if (sel1_cnt !== 8'd0) begin errors++; $display("FAIL reset_sel1 got %0d exp 0", sel1_cnt); end
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_comb();
    logic [2:0] v;
    logic       e;
    en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      v = 3'(k);
      {select, i1, i0} = v;
      e = v[2] ? v[1] : v[0];
      #10;
      checks++;
      if (y !== e) begin errors++; $display("FAIL comb sel=%b i1=%b i0=%b y got %b exp %b", select, i1, i0, y, e); end
    end
  endtask
  task automatic test_random();
    logic [1:0] p;
    logic       s, e;
    for (int k = 0; k < 15; k++) begin
      p = 2'($urandom_range(0, 3));
      s = 1'($urandom_range(0, 1));
      i0 = p[0];
      i1 = p[1];
      select = s;
      e = s ? p[1] : p[0];
      #3;
      checks++;
      if (y !== e) begin errors++; $display("FAIL random iter %0d y got %b exp %b", k, y, e); end
    end
  endtask
  task automatic test_registered();
    do_reset();
    en = 1'b1; i0 = 1'b0; i1 = 1'b1; select = 1'b1;
    @(posedge clk); #1;
    checks += 4;
    if (y_q !== 1'b1) begin errors++; $display("FAIL reg_y_q got %b exp 1", y_q); end
    if (y_q_valid !== 1'b1) begin errors++; $display("FAIL reg_valid got %b exp 1", y_q_valid); end
    if (sel1_cnt !== 8'd1) begin errors++; $display("FAIL reg_sel1 got %0d exp 1", sel1_cnt); end
    if (sel0_cnt !== 8'd0) begin errors++; $display("FAIL reg_sel0 got %0d exp 0", sel0_cnt); end
    @(negedge clk);
    en = 1'b0; select = 1'b0;
    @(posedge clk); #1;
    checks += 3;
    if (y_q !== 1'b1) begin errors++; $display("FAIL hold_y_q got %b exp 1", y_q); end
    if (y_q_valid !== 1'b0) begin errors++; $display("FAIL hold_valid got %b exp 0", y_q_valid); end
    if (sel1_cnt !== 8'd1) begin errors++; $display("FAIL hold_sel1 got %0d exp 1", sel1_cnt); end
  endtask
  task automatic test_async_reset();
    do_reset();
    en = 1'b1; i0 = 1'b0; i1 = 1'b1; select = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks += 2;
    if (y_q !== 1'b1) begin errors++; $display("FAIL pre_rst_y_q got %b exp 1", y_q); end
    if (sel1_cnt !== 8'd5) begin errors++; $display("FAIL pre_rst_sel1 got %0d exp 5", sel1_cnt); end
    #2;
    rst = 1'b1;
    #1;
    checks += 4;
    if (y_q !== 1'b0) begin errors++; $display("FAIL arst_y_q got %b exp 0", y_q); end
    if (y_q_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b exp 0", y_q_valid); end
    if (sel0_cnt !== 8'd0) begin errors++; $display("FAIL arst_sel0 got %0d exp 0", sel0_cnt); end
    if (sel1_cnt !== 8'd0) begin errors++; $display("FAIL arst_sel1 got %0d exp 0", sel1_cnt); end
    @(negedge clk);
    en = 1'b0;
    rst = 1'b0;
  endtask
  task automatic test_saturation();
    do_reset();
    en = 1'b1; select = 1'b0; i0 = 1'b1; i1 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks += 4;
    if (s0_small !== 2'd3) begin errors++; $display("FAIL sat_sel0 got %0d exp 3", s0_small); end
    if (s1_small !== 2'd0) begin errors++; $display("FAIL sat_sel1 got %0d exp 0", s1_small); end
    if (sel0_cnt !== 8'd5) begin errors++; $display("FAIL wide_sel0 got %0d exp 5", sel0_cnt); end
    if (sel1_cnt !== 8'd0) begin errors++; $display("FAIL wide_sel1 got %0d exp 0", sel1_cnt); end
    @(negedge clk);
    en = 1'b0;
  endtask
  task automatic test_back_to_back();
    logic [3:0] seq_s = 4'b0110;
    logic [3:0] seq_i0 = 4'b1010;
    logic [3:0] seq_i1 = 4'b0011;
    logic       e;
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      select = seq_s[k]; i0 = seq_i0[k]; i1 = seq_i1[k];
      e = seq_s[k] ? seq_i1[k] : seq_i0[k];
      @(posedge clk); #1;
      checks++;
      if (y_q !== e) begin errors++; $display("FAIL b2b step %0d y_q got %b exp %b", k, y_q, e); end
      @(negedge clk);
    end
    en = 1'b0;
    checks += 2;
    if (sel0_cnt !== 8'd2) begin errors++; $display("FAIL b2b_sel0 got %0d exp 2", sel0_cnt); end
    if (sel1_cnt !== 8'd2) begin errors++; $display("FAIL b2b_sel1 got %0d exp 2", sel1_cnt); end
  endtask
`ifdef MUX_2X1_MPC_CHECK_EN
  task automatic test_check();
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      {select, i1, i0} = 3'($urandom_range(0, 7));
      @(negedge clk);
    end
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (err_sticky !== 1'b0) begin errors++; $display("FAIL chk_err got %b exp 0", err_sticky); end
    rst = 1'b1;
    #1;
    checks++;
    if (err_sticky !== 1'b0) begin errors++; $display("FAIL chk_err_rst got %b exp 0", err_sticky); end
    @(negedge clk);
    rst = 1'b0;
  endtask
`endif
  initial begin
    test_reset();
    test_comb();
    test_random();
    test_registered();
    test_async_reset();
    test_saturation();
    test_back_to_back();
`ifdef MUX_2X1_MPC_CHECK_EN
    test_check();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
